// File: rtl/contador_bcd_n.sv
// contador_bcd_n: parametrised multi-digit packed-BCD up/down counter with terminal ticks and wrap flag.
// Optional parallel load path is compiled in when CONTADOR_BCD_LOAD_EN is defined.
module contador_bcd_n #(
  parameter int unsigned         DIGITS  = 3,
  parameter logic [4*DIGITS-1:0] MAX_BCD = {DIGITS{4'h9}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
`ifdef CONTADOR_BCD_LOAD_EN
  input  logic                load,
  input  logic [4*DIGITS-1:0] d,
`endif
  output logic [4*DIGITS-1:0] q,
  output logic                max_tick,
  output logic                min_tick,
  output logic                wrap
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam logic [W-1:0] ZERO = '0;

  logic [W-1:0] q_q, q_d;
  logic [W-1:0] inc_c, dec_c;
  logic         wrap_q, wrap_d;
  logic         at_max_c, at_min_c;

  assign at_max_c = (q_q == MAX_BCD);
  assign at_min_c = (q_q == ZERO);

  // Decimal ripple: a digit steps only when every lower digit carried/borrowed.
  always_comb begin
    logic carry;
    logic borrow;
    inc_c  = q_q;
    dec_c  = q_q;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (q_q[4*i +: 4] == 4'd9) begin
          inc_c[4*i +: 4] = 4'd0;
        end else begin
          inc_c[4*i +: 4] = 4'(q_q[4*i +: 4] + 4'd1);
          carry           = 1'b0;
        end
      end
      if (borrow) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          dec_c[4*i +: 4] = 4'd9;
        end else begin
          dec_c[4*i +: 4] = 4'(q_q[4*i +: 4] - 4'd1);
          borrow          = 1'b0;
        end
      end
    end
  end

`ifdef CONTADOR_BCD_LOAD_EN
  logic d_ok_c;

  // A load value is accepted only if it is valid BCD and inside the counting range.
  always_comb begin
    d_ok_c = (d <= MAX_BCD);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > 4'd9) begin
        d_ok_c = 1'b0;
      end
    end
  end
`endif

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d = ZERO;
    end
`ifdef CONTADOR_BCD_LOAD_EN
    else if (load) begin
      q_d = d_ok_c ? d : ZERO;
    end
`endif
    else if (en) begin
      if (up) begin
        if (at_max_c) begin
          q_d    = ZERO;
          wrap_d = 1'b1;
        end else begin
          q_d = inc_c;
        end
      end else begin
        if (at_min_c) begin
          q_d    = MAX_BCD;
          wrap_d = 1'b1;
        end else begin
          q_d = dec_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= ZERO;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q        = q_q;
  assign wrap     = wrap_q;
  assign max_tick = en & up & at_max_c;
  assign min_tick = en & ~up & at_min_c;

endmodule

// File: tb/tb_contador_bcd_n.sv
// tb_contador_bcd_n: directed and randomized checks of contador_bcd_n against a decimal-integer model.
// Load checks are compiled only when CONTADOR_BCD_LOAD_EN is defined.
module tb_contador_bcd_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, up = 1'b1, clr = 1'b0;
  logic        load = 1'b0;
  logic [11:0] d = 12'h000;
  logic [11:0] q_a, q_b;
  logic        max_a, min_a, wrap_a, max_b, min_b, wrap_b;

  logic        casc_en = 1'b0, casc_clr = 1'b0;
  logic [3:0]  cq0, cq1;
  logic        cmax0, cmin0, cw0, cmax1, cmin1, cw1;

  int vectors = 0;
  int errors  = 0;

  // Model state: plain decimal integers plus wrap flags.
  int va = 0, vb = 0;
  bit wa = 1'b0, wb = 1'b0;

  always #5 clk = ~clk;

  contador_bcd_n #(.DIGITS(3)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr),
`ifdef CONTADOR_BCD_LOAD_EN
    .load(load), .d(d),
`endif
    .q(q_a), .max_tick(max_a), .min_tick(min_a), .wrap(wrap_a));

  contador_bcd_n #(.DIGITS(3), .MAX_BCD(12'h059)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr),
`ifdef CONTADOR_BCD_LOAD_EN
    .load(load), .d(d),
`endif
    .q(q_b), .max_tick(max_b), .min_tick(min_b), .wrap(wrap_b));

  contador_bcd_n #(.DIGITS(1)) dut_c0 (
    .clk(clk), .reset(reset), .en(casc_en), .up(1'b1), .clr(casc_clr),
`ifdef CONTADOR_BCD_LOAD_EN
    .load(1'b0), .d(4'h0),
`endif
    .q(cq0), .max_tick(cmax0), .min_tick(cmin0), .wrap(cw0));

  contador_bcd_n #(.DIGITS(1)) dut_c1 (
    .clk(clk), .reset(reset), .en(cmax0), .up(1'b1), .clr(casc_clr),
`ifdef CONTADOR_BCD_LOAD_EN
    .load(1'b0), .d(4'h0),
`endif
    .q(cq1), .max_tick(cmax1), .min_tick(cmin1), .wrap(cw1));

  function automatic logic [11:0] int2bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int bcd2int(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [11:0] b);
    return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic int nxt_v(input int v, input int mx, input logic c, input logic ld,
                               input logic [11:0] dd, input logic e, input logic u);
    if (c) return 0;
    if (ld) return (bcd_ok(dd) && bcd2int(dd) <= mx) ? bcd2int(dd) : 0;
    if (!e) return v;
    if (u) return (v == mx) ? 0 : v + 1;
    return (v == 0) ? mx : v - 1;
  endfunction

  function automatic bit nxt_w(input int v, input int mx, input logic c, input logic ld,
                               input logic e, input logic u);
    if (c || ld || !e) return 1'b0;
    return u ? (v == mx) : (v == 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      va <= 0; wa <= 1'b0; vb <= 0; wb <= 1'b0;
    end else begin
      va <= nxt_v(va, 999, clr, load, d, en, up);
      wa <= nxt_w(va, 999, clr, load, en, up);
      vb <= nxt_v(vb, 59, clr, load, d, en, up);
      wb <= nxt_w(vb, 59, clr, load, en, up);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("q_a", 32'(q_a), 32'(int2bcd(va)));
    chk("wrap_a", 32'(wrap_a), 32'(wa));
    chk("max_tick_a", 32'(max_a), 32'(en && up && va == 999));
    chk("min_tick_a", 32'(min_a), 32'(en && !up && va == 0));
    chk("q_b", 32'(q_b), 32'(int2bcd(vb)));
    chk("wrap_b", 32'(wrap_b), 32'(wb));
    chk("max_tick_b", 32'(max_b), 32'(en && up && vb == 59));
    chk("min_tick_b", 32'(min_b), 32'(en && !up && vb == 0));
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 1'b1; up = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst q", 32'(q_a), 32'h0);
    chk("rst wrap", 32'(wrap_a), 32'h0);
    chk("rst min_tick", 32'(min_a), 32'h1);
    chk("rst max_tick", 32'(max_a), 32'h0);
    up = 1'b1;
    #1 chk("rst up min_tick", 32'(min_a), 32'h0);
    tick();
    tick();
    reset = 1'b1;

    for (int k = 1; k <= 999; k++) begin
      tick();
      if (k == 9)   chk("up 009", 32'(q_a), 32'h009);
      if (k == 10)  chk("up 010", 32'(q_a), 32'h010);
      if (k == 59)  chk("b at 059", 32'(q_b), 32'h059);
      if (k == 59)  chk("b max_tick", 32'(max_b), 32'h1);
      if (k == 60)  chk("b wrap q", 32'(q_b), 32'h000);
      if (k == 60)  chk("b wrap", 32'(wrap_b), 32'h1);
      if (k == 100) chk("up 100", 32'(q_a), 32'h100);
    end
    chk("at 999", 32'(q_a), 32'h999);
    chk("max_tick 999", 32'(max_a), 32'h1);
    tick();
    chk("wrap up q", 32'(q_a), 32'h000);
    chk("wrap up flag", 32'(wrap_a), 32'h1);
    tick();
    chk("wrap one cycle", 32'(wrap_a), 32'h0);

    clr = 1'b1; tick(); clr = 1'b0; up = 1'b0;
    #1 chk("min_tick 000", 32'(min_a), 32'h1);
    tick();
    chk("down wrap q", 32'(q_a), 32'h999);
    chk("down wrap flag", 32'(wrap_a), 32'h1);
    chk("b down wrap q", 32'(q_b), 32'h059);

    up = 1'b1; clr = 1'b1;
    tick();
    chk("clr beats wrap q", 32'(q_a), 32'h000);
    chk("clr beats wrap flag", 32'(wrap_a), 32'h0);
    clr = 1'b0; up = 1'b0;
    tick();
    repeat (899) tick();
    chk("down 100", 32'(q_a), 32'h100);
    tick();
    chk("borrow 099", 32'(q_a), 32'h099);

    clr = 1'b1; tick(); clr = 1'b0; up = 1'b1;
    repeat (347) tick();
    chk("at 347", 32'(q_a), 32'h347);
    #1 reset = 1'b0;
    #1 chk("async rst q", 32'(q_a), 32'h000);
    chk("async rst wrap", 32'(wrap_a), 32'h0);
    #1 reset = 1'b1;
    tick();
    en = 1'b0;
    repeat (3) tick();
    chk("hold", 32'(q_a), 32'h001);

`ifdef CONTADOR_BCD_LOAD_EN
    load = 1'b1; d = 12'h123; tick();
    chk("load 123", 32'(q_a), 32'h123);
    load = 1'b0; en = 1'b1; up = 1'b1; tick();
    chk("count 124", 32'(q_a), 32'h124);
    load = 1'b1; d = 12'h1A3; tick();
    chk("load bad nibble", 32'(q_a), 32'h000);
    d = 12'h060; tick();
    chk("load 060", 32'(q_a), 32'h060);
    chk("b load over max", 32'(q_b), 32'h000);
    clr = 1'b1; d = 12'h123; tick();
    chk("clr beats load", 32'(q_a), 32'h000);
    clr = 1'b0; load = 1'b0;
`endif

    for (int n = 0; n < 3000; n++) begin
      en  = ($urandom_range(0, 3) != 0);
      up  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
`ifdef CONTADOR_BCD_LOAD_EN
      load = ($urandom_range(0, 7) == 0);
      d    = $urandom_range(0, 1) ? int2bcd(int'($urandom_range(0, 999))) : 12'($urandom);
`endif
      reset = ($urandom_range(0, 63) != 0);
      tick();
    end
    reset = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0;

    casc_clr = 1'b1; tick(); casc_clr = 1'b0; casc_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      if (i == 100) begin
        #1 chk("casc max_tick 99", 32'(cmax1), 32'h1);
      end
      tick();
      chk("casc value", int'(cq1) * 10 + int'(cq0), 32'(i % 100));
      if (i == 100) chk("casc wrap", 32'(cw1), 32'h1);
    end
    tick();
    chk("casc wrap one cycle", 32'(cw1), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
